// File: rtl/event_irq_pkg.sv
// Shared register map, CTRL field layout and interrupt-level helper for the
// multi-channel event interrupt bank.
package event_irq_pkg;

    localparam logic [3:0] OFF_DATA     = 4'h0;
    localparam logic [3:0] OFF_STATUS   = 4'h4;
    localparam logic [3:0] OFF_CTRL     = 4'h8;
    localparam int         CHAN_STRIDE  = 'h10;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_DROP_BIT  = 1;
    localparam int CTRL_THR_LSB   = 8;
    localparam int CTRL_THR_MSB   = 15;
    localparam int STATUS_OVF_BIT = 31;

    typedef struct packed {
        logic [7:0] threshold;
        logic       drop_mode;
        logic       enable;
    } ctrl_reg_t;

    // A threshold of 0 behaves like 1 so an enabled channel never asserts
    // its interrupt while its FIFO is empty.
    function automatic logic irq_level(input logic [15:0] count,
                                       input logic [7:0]  thr);
        logic [15:0] eff;
        eff = (thr == 8'd0) ? 16'd1 : {8'd0, thr};
        return (count >= eff);
    endfunction

endpackage

// File: rtl/event_chan_fifo.sv
// Single-channel event ID FIFO. In drop mode a push into a full FIFO is
// accepted on the interface but discarded, and reported through drop_o.
module event_chan_fifo
    import event_irq_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_valid_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          drop_mode_i,
    input  logic          pop_i,
    output logic          ready_o,
    output logic [DW-1:0] head_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          drop_o
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Full/ready come from the pre-pop count, so a pop never opens ready
    // combinationally in the same cycle.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = push_valid_i & ~w_full;
    assign w_pop   = pop_i & ~w_empty;

    assign ready_o = ~w_full | drop_mode_i;
    assign head_o  = r_mem[r_rptr];
    assign count_o = r_count;
    assign empty_o = w_empty;
    assign drop_o  = push_valid_i & w_full & drop_mode_i;

    // Storage needs no reset: entries are only visible while count says so.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= push_data_i;
        end
    end

    // Pointers wrap naturally; count tracks occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/event_irq_bank.sv
// Multi-channel event-to-level interrupt bank: per-channel event FIFOs,
// CTRL / overflow-sticky registers behind an APB window, registered irqs.
module event_irq_bank
    import event_irq_pkg::*;
#(
    parameter int EVENT_ID_WIDTH = 8,
    parameter int NB_CHANNELS    = 4,
    parameter int FIFO_DEPTH     = 8,
    parameter int APB_ADDR_WIDTH = 12
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic [NB_CHANNELS-1:0]                    event_valid_i,
    input  logic [NB_CHANNELS-1:0][EVENT_ID_WIDTH-1:0] event_data_i,
    output logic [NB_CHANNELS-1:0]                    event_ready_o,
    input  logic                                      psel_i,
    input  logic                                      penable_i,
    input  logic                                      pwrite_i,
    input  logic [APB_ADDR_WIDTH-1:0]                 paddr_i,
    input  logic [31:0]                               pwdata_i,
    output logic [31:0]                               prdata_o,
    output logic                                      pready_o,
    output logic                                      pslverr_o,
    output logic [NB_CHANNELS-1:0]                    irq_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_W = APB_ADDR_WIDTH - 4;

    logic                      w_acc;
    logic                      w_rd;
    logic                      w_wr;
    logic [IDX_W-1:0]          w_ch_idx;
    logic                      w_in_range;
    logic [3:0]                w_off;
    logic [31:0]               w_prdata;
    logic                      w_pslverr;
    logic                      w_unused_bits;

    ctrl_reg_t                 r_ctrl [NB_CHANNELS];
    logic [NB_CHANNELS-1:0]    r_ovf;
    logic [NB_CHANNELS-1:0]    r_irq;
    logic [NB_CHANNELS-1:0]    w_sel;
    logic [NB_CHANNELS-1:0]    w_pop;
    logic [NB_CHANNELS-1:0]    w_drop;
    logic [NB_CHANNELS-1:0]    w_empty;
    logic [NB_CHANNELS-1:0]    w_ovf_clr;
    logic [NB_CHANNELS-1:0]    w_ctrl_wr;
    logic [CNT_W-1:0]          w_count [NB_CHANNELS];
    logic [EVENT_ID_WIDTH-1:0] w_head  [NB_CHANNELS];

    assign w_acc      = psel_i & penable_i;
    assign w_rd       = w_acc & ~pwrite_i;
    assign w_wr       = w_acc & pwrite_i;
    assign w_ch_idx   = paddr_i[APB_ADDR_WIDTH-1:4];
    assign w_in_range = ({1'b0, w_ch_idx} < (IDX_W+1)'(NB_CHANNELS));
    assign w_off      = {paddr_i[3:2], 2'b00};

    assign w_unused_bits = ^{paddr_i[1:0], pwdata_i[30:16], pwdata_i[7:2]};

    for (genvar c = 0; c < NB_CHANNELS; c++) begin : g_chan
        assign w_sel[c]     = w_in_range & (w_ch_idx == IDX_W'(c));
        assign w_pop[c]     = w_rd & w_sel[c] & (w_off == OFF_DATA);
        assign w_ovf_clr[c] = w_wr & w_sel[c] & (w_off == OFF_STATUS)
                              & pwdata_i[STATUS_OVF_BIT];
        assign w_ctrl_wr[c] = w_wr & w_sel[c] & (w_off == OFF_CTRL);

        event_chan_fifo #(
            .DW    (EVENT_ID_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .push_valid_i (event_valid_i[c]),
            .push_data_i  (event_data_i[c]),
            .drop_mode_i  (r_ctrl[c].drop_mode),
            .pop_i        (w_pop[c]),
            .ready_o      (event_ready_o[c]),
            .head_o       (w_head[c]),
            .count_o      (w_count[c]),
            .empty_o      (w_empty[c]),
            .drop_o       (w_drop[c])
        );
    end

    // CTRL write, overflow sticky (a new drop wins over a same-cycle clear)
    // and registered interrupt level per channel.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NB_CHANNELS; c++) begin
                r_ctrl[c] <= '0;
            end
            r_ovf <= '0;
            r_irq <= '0;
        end else begin
            for (int c = 0; c < NB_CHANNELS; c++) begin
                if (w_ctrl_wr[c]) begin
                    r_ctrl[c].threshold <= pwdata_i[CTRL_THR_MSB:CTRL_THR_LSB];
                    r_ctrl[c].drop_mode <= pwdata_i[CTRL_DROP_BIT];
                    r_ctrl[c].enable    <= pwdata_i[CTRL_EN_BIT];
                end
                r_ovf[c] <= (r_ovf[c] & ~w_ovf_clr[c]) | w_drop[c];
                r_irq[c] <= r_ctrl[c].enable
                            & irq_level(16'(w_count[c]), r_ctrl[c].threshold);
            end
        end
    end

    // Read mux and error response; both stay zero outside the access phase.
    always_comb begin
        w_prdata  = '0;
        w_pslverr = 1'b0;
        if (w_acc) begin
            if (!w_in_range) begin
                w_pslverr = 1'b1;
            end else if (!pwrite_i) begin
                for (int c = 0; c < NB_CHANNELS; c++) begin
                    if (w_sel[c]) begin
                        case (w_off)
                            OFF_DATA: begin
                                if (!w_empty[c]) begin
                                    w_prdata[31]                  = 1'b1;
                                    w_prdata[EVENT_ID_WIDTH-1:0] = w_head[c];
                                end
                            end
                            OFF_STATUS: begin
                                w_prdata[STATUS_OVF_BIT] = r_ovf[c];
                                w_prdata[CNT_W-1:0]      = w_count[c];
                            end
                            OFF_CTRL: begin
                                w_prdata[CTRL_EN_BIT]   = r_ctrl[c].enable;
                                w_prdata[CTRL_DROP_BIT] = r_ctrl[c].drop_mode;
                                w_prdata[CTRL_THR_MSB:CTRL_THR_LSB] = r_ctrl[c].threshold;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    assign prdata_o  = w_prdata;
    assign pslverr_o = w_pslverr;
    assign pready_o  = 1'b1;
    assign irq_o     = r_irq;

endmodule

// File: tb/tb_event_irq_bank.sv
// Directed test of the event interrupt bank with hand-computed expectations.
module tb_event_irq_bank;

    logic             clk;
    logic             rst_n;
    logic [3:0]       ev_valid;
    logic [3:0][7:0]  ev_data;
    logic [3:0]       ev_ready;
    logic             psel;
    logic             penable;
    logic             pwrite;
    logic [11:0]      paddr;
    logic [31:0]      pwdata;
    logic [31:0]      prdata;
    logic             pready;
    logic             pslverr;
    logic [3:0]       irq;

    int checks = 0;
    int errors = 0;

    event_irq_bank #(
        .EVENT_ID_WIDTH (8),
        .NB_CHANNELS    (4),
        .FIFO_DEPTH     (8),
        .APB_ADDR_WIDTH (12)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .event_valid_i (ev_valid),
        .event_data_i  (ev_data),
        .event_ready_o (ev_ready),
        .psel_i        (psel),
        .penable_i     (penable),
        .pwrite_i      (pwrite),
        .paddr_i       (paddr),
        .pwdata_i      (pwdata),
        .prdata_o      (prdata),
        .pready_o      (pready),
        .pslverr_o     (pslverr),
        .irq_o         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks start and end on a falling edge.
    task automatic apb_rd(input logic [11:0] a, output logic [31:0] d, output logic e);
        paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b1;
        #1;
        d = prdata; e = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic apb_wr(input logic [11:0] a, input logic [31:0] d);
        paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic push(input int ch, input logic [7:0] id);
        ev_valid[ch] = 1'b1; ev_data[ch] = id;
        @(negedge clk);
        ev_valid[ch] = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic e;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (irq !== 4'b0000 || ev_ready !== 4'b1111 || prdata !== 32'h0 || pslverr !== 1'b0 || pready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: irq=%b ready=%b prdata=%h err=%b pready=%b want irq=0000 ready=1111 prdata=0 err=0 pready=1",
                     irq, ev_ready, prdata, pslverr, pready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        apb_rd(12'h000, d, e);
        checks++;
        if (d !== 32'h0 || e !== 1'b0) begin
            errors++; $display("FAIL reset_data: got %h err %b want 00000000 err 0", d, e);
        end
        apb_rd(12'h004, d, e);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL reset_status: got %h want 00000000", d);
        end
        checks++;
        if (irq !== 4'b0000 || ev_ready !== 4'b1111) begin
            errors++; $display("FAIL reset_after_reads: irq=%b ready=%b want 0000 1111", irq, ev_ready);
        end
        // Outside the access phase the read bus stays at zero.
        paddr = 12'h008; psel = 1'b1; penable = 1'b0; #1;
        checks++;
        if (prdata !== 32'h0) begin
            errors++; $display("FAIL setup_phase_prdata: got %h want 00000000", prdata);
        end
        @(negedge clk); psel = 1'b0;
    endtask

    task automatic test_threshold();
        logic [31:0] d; logic e;
        logic [31:0] exp_d [3] = '{32'h8000_0011, 32'h8000_0022, 32'h8000_0033};
        apb_wr(12'h018, 32'h0000_0301);
        apb_rd(12'h018, d, e);
        checks++;
        if (d !== 32'h0000_0301) begin
            errors++; $display("FAIL thr_ctrl_readback: got %h want 00000301", d);
        end
        push(1, 8'h11);
        push(1, 8'h22);
        push(1, 8'h33);
        checks++;
        if (irq[1] !== 1'b0) begin
            errors++; $display("FAIL thr_irq_early: got %b want 0", irq[1]);
        end
        @(negedge clk);
        checks++;
        if (irq[1] !== 1'b1) begin
            errors++; $display("FAIL thr_irq_rise: got %b want 1", irq[1]);
        end
        for (int i = 0; i < 3; i++) begin
            apb_rd(12'h010, d, e);
            checks++;
            if (d !== exp_d[i]) begin
                errors++; $display("FAIL thr_data_%0d: got %h want %h", i, d, exp_d[i]);
            end
            if (i == 0) begin
                @(negedge clk);
                checks++;
                if (irq[1] !== 1'b0) begin
                    errors++; $display("FAIL thr_irq_fall: got %b want 0", irq[1]);
                end
            end
        end
        apb_rd(12'h010, d, e);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL thr_empty_read: got %h want 00000000", d);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d; logic e;
        for (int i = 0; i < 8; i++) push(2, 8'h50 + 8'(i));
        ev_valid[2] = 1'b1; ev_data[2] = 8'hAA;
        #1;
        checks++;
        if (ev_ready[2] !== 1'b0) begin
            errors++; $display("FAIL bp_ready_full: got %b want 0", ev_ready[2]);
        end
        apb_rd(12'h024, d, e);
        checks++;
        if (d !== 32'h0000_0008) begin
            errors++; $display("FAIL bp_status_full: got %h want 00000008", d);
        end
        apb_rd(12'h020, d, e);
        checks++;
        if (d !== 32'h8000_0050) begin
            errors++; $display("FAIL bp_pop_head: got %h want 80000050", d);
        end
        checks++;
        if (ev_ready[2] !== 1'b1) begin
            errors++; $display("FAIL bp_ready_back: got %b want 1", ev_ready[2]);
        end
        @(negedge clk);
        ev_valid[2] = 1'b0;
        apb_rd(12'h024, d, e);
        checks++;
        if (d !== 32'h0000_0008) begin
            errors++; $display("FAIL bp_status_refill: got %h want 00000008", d);
        end
        for (int i = 1; i < 9; i++) begin
            logic [31:0] x;
            x = (i == 8) ? 32'h8000_00AA : 32'h8000_0050 + 32'(i);
            apb_rd(12'h020, d, e);
            checks++;
            if (d !== x) begin
                errors++; $display("FAIL bp_drain_%0d: got %h want %h", i, d, x);
            end
        end
    endtask

    task automatic test_drop();
        logic [31:0] d; logic e;
        apb_wr(12'h038, 32'h0000_0002);
        for (int i = 0; i < 8; i++) push(3, 8'h60 + 8'(i));
        checks++;
        if (ev_ready[3] !== 1'b1) begin
            errors++; $display("FAIL drop_ready_full: got %b want 1", ev_ready[3]);
        end
        push(3, 8'hBB);
        apb_rd(12'h034, d, e);
        checks++;
        if (d !== 32'h8000_0008) begin
            errors++; $display("FAIL drop_status_ovf: got %h want 80000008", d);
        end
        apb_wr(12'h034, 32'h8000_0000);
        apb_rd(12'h034, d, e);
        checks++;
        if (d !== 32'h0000_0008) begin
            errors++; $display("FAIL drop_status_clr: got %h want 00000008", d);
        end
        // Clear and new overflow in the same cycle: the set wins.
        ev_valid[3] = 1'b1; ev_data[3] = 8'hCC;
        apb_wr(12'h034, 32'h8000_0000);
        ev_valid[3] = 1'b0;
        apb_rd(12'h034, d, e);
        checks++;
        if (d !== 32'h8000_0008) begin
            errors++; $display("FAIL drop_set_wins: got %h want 80000008", d);
        end
        apb_wr(12'h034, 32'h8000_0000);
        // Full, drop mode, pop and push together: pop happens, push is dropped.
        ev_valid[3] = 1'b1; ev_data[3] = 8'hDD;
        apb_rd(12'h030, d, e);
        ev_valid[3] = 1'b0;
        checks++;
        if (d !== 32'h8000_0060) begin
            errors++; $display("FAIL drop_pop_head: got %h want 80000060", d);
        end
        apb_rd(12'h034, d, e);
        checks++;
        if (d !== 32'h8000_0007) begin
            errors++; $display("FAIL drop_pop_status: got %h want 80000007", d);
        end
        apb_rd(12'h030, d, e);
        checks++;
        if (d !== 32'h8000_0061) begin
            errors++; $display("FAIL drop_next_head: got %h want 80000061", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic e;
        for (int i = 0; i < 4; i++) push(0, 8'(i));
        for (int i = 0; i < 20; i++) begin
            ev_valid[0] = 1'b1; ev_data[0] = 8'(i + 4);
            apb_rd(12'h000, d, e);
            checks++;
            if (d !== (32'h8000_0000 | 32'(i))) begin
                errors++; $display("FAIL b2b_pop_%0d: got %h want %h", i, d, 32'h8000_0000 | 32'(i));
            end
        end
        ev_valid[0] = 1'b0;
        apb_rd(12'h004, d, e);
        checks++;
        if (d !== 32'h0000_0004) begin
            errors++; $display("FAIL b2b_count: got %h want 00000004", d);
        end
        for (int i = 20; i < 24; i++) begin
            apb_rd(12'h000, d, e);
            checks++;
            if (d !== (32'h8000_0000 | 32'(i))) begin
                errors++; $display("FAIL b2b_drain_%0d: got %h want %h", i, d, 32'h8000_0000 | 32'(i));
            end
        end
    endtask

    task automatic test_apb_error();
        logic [31:0] d; logic e;
        push(0, 8'h77);
        apb_rd(12'h040, d, e);
        checks++;
        if (e !== 1'b1 || d !== 32'h0) begin
            errors++; $display("FAIL err_read: err %b data %h want err 1 data 00000000", e, d);
        end
        paddr = 12'h048; pwdata = 32'h0000_0001; pwrite = 1'b1; psel = 1'b1; penable = 1'b1;
        #1;
        checks++;
        if (pslverr !== 1'b1) begin
            errors++; $display("FAIL err_write: err %b want 1", pslverr);
        end
        @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        apb_rd(12'h004, d, e);
        checks++;
        if (d !== 32'h0000_0001) begin
            errors++; $display("FAIL err_no_pop: got %h want 00000001", d);
        end
        apb_rd(12'h00C, d, e);
        checks++;
        if (d !== 32'h0 || e !== 1'b0) begin
            errors++; $display("FAIL reserved_read: data %h err %b want 00000000 err 0", d, e);
        end
        apb_wr(12'h008, 32'h0000_FF23);
        apb_rd(12'h008, d, e);
        checks++;
        if (d !== 32'h0000_FF03) begin
            errors++; $display("FAIL ctrl_mask: got %h want 0000ff03", d);
        end
        // Threshold above the FIFO depth never fires.
        repeat (2) @(negedge clk);
        checks++;
        if (irq[0] !== 1'b0) begin
            errors++; $display("FAIL irq_thr_high: got %b want 0", irq[0]);
        end
        // Threshold 0 acts as 1.
        apb_wr(12'h008, 32'h0000_0001);
        @(negedge clk);
        checks++;
        if (irq[0] !== 1'b1) begin
            errors++; $display("FAIL irq_thr_zero: got %b want 1", irq[0]);
        end
        // Disabling masks the interrupt but the FIFO still accepts.
        apb_wr(12'h008, 32'h0000_0000);
        push(0, 8'h78);
        checks++;
        if (irq[0] !== 1'b0) begin
            errors++; $display("FAIL irq_disabled: got %b want 0", irq[0]);
        end
        apb_rd(12'h004, d, e);
        checks++;
        if (d !== 32'h0000_0002) begin
            errors++; $display("FAIL disabled_accepts: got %h want 00000002", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic e;
        apb_wr(12'h008, 32'h0000_0001);
        @(negedge clk);
        checks++;
        if (irq[0] !== 1'b1) begin
            errors++; $display("FAIL mid_irq_pre: got %b want 1", irq[0]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (irq !== 4'b0000 || ev_ready !== 4'b1111) begin
            errors++; $display("FAIL mid_async: irq=%b ready=%b want 0000 1111", irq, ev_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        apb_rd(12'h004, d, e);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL mid_status: got %h want 00000000", d);
        end
        apb_rd(12'h008, d, e);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL mid_ctrl: got %h want 00000000", d);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ev_valid = '0; ev_data = '0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        @(negedge clk);
        test_reset();
        test_threshold();
        test_backpressure();
        test_drop();
        test_back_to_back();
        test_apb_error();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/event_irq_bank.md
Name: event_irq_bank

Overview:
- Multi-channel successor to the single-stream SoC event-to-level interrupt converter in the FC subsystem.
- NB_CHANNELS independent event streams, each buffered in its own FIFO of event IDs.
- Each channel drives one level-sensitive interrupt line into the CLIC, with a programmable fill threshold and a selectable overflow policy (backpressure or drop-and-flag).
- Software drains events through a memory-mapped APB register window.

Parameters:
- EVENT_ID_WIDTH, 8, width of one event ID; must be ≤ 31.
- NB_CHANNELS, 4, number of event streams, FIFOs and interrupt lines; range 1..16.
- FIFO_DEPTH, 8, entries per channel FIFO; must be a power of two, ≥ 2.
- APB_ADDR_WIDTH, 12, width of paddr_i.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- event_valid_i  in  NB_CHANNELS  per-channel event valid.
- event_data_i  in  NB_CHANNELS x EVENT_ID_WIDTH  per-channel event ID.
- event_ready_o  out  NB_CHANNELS  per-channel ready.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable.
- pwrite_i  in  1  APB write.
- paddr_i  in  APB_ADDR_WIDTH  APB byte address.
- pwdata_i  in  32  APB write data.
- prdata_o  out  32  APB read data.
- pready_o  out  1  APB ready; tied to 1.
- pslverr_o  out  1  APB error.
- irq_o  out  NB_CHANNELS  level interrupt per channel.

Behaviour:
- Clocking and reset: one clock, clk_i; reset rst_ni is asynchronous, active-low.
- Reset state:
  - all FIFOs empty; count = 0;
  - CTRL = 0 (enable = 0, drop_mode = 0, threshold = 0); overflow sticky = 0;
  - outputs: irq_o = 0, event_ready_o = all 1, prdata_o = 0, pslverr_o = 0.
- Access timing: an APB access takes effect in the cycle where psel_i & penable_i is high.
  - pready_o = 1, so there are no wait states.
  - prdata_o and pslverr_o are combinational during that cycle and 0 otherwise.
- Register map: channel c occupies base c*0x10.
  - +0x0 DATA (RO, read pops):
    - non-empty: returns {1'b1, zeros, head ID} and pops.
    - empty: returns 0 and changes nothing.
    - writes are ignored.
  - +0x4 STATUS:
    - bits[15:0] = count (RO).
    - bit31 = overflow sticky (RW1C).
  - +0x8 CTRL (RW):
    - bit0 = enable.
    - bit1 = drop_mode.
    - bits[15:8] = threshold.
    - other bits read 0.
  - +0xC: reserved; reads 0, writes ignored, no error.
  - Address ≥ NB_CHANNELS*0x10: pslverr_o = 1, read data 0, no side effects.
  - paddr_i[1:0] is ignored.
- Push path:
  - A push occurs when event_valid_i[c] & event_ready_o[c] are both high.
  - An accepted event is written at the tail on the rising edge; count increments in the next cycle.
  - event_ready_o[c] = !full[c] | drop_mode[c]. It depends on registered state only, with no combinational path from pop.
- Full FIFO:
  - Backpressure mode: ready is low; the producer holds the event.
  - Drop mode: the event is accepted and discarded; overflow sticky is set in the next cycle.
- Same-cycle push and pop:
  - FIFO not full: both take effect; count is unchanged.
  - FIFO full, drop mode: the pop takes effect and the incoming event is still discarded and flagged, because ready/full is evaluated on the pre-pop state.
- Overflow sticky: a RW1C clear in the same cycle as a new overflow leaves the bit set (set wins).
- Pointer and count arithmetic:
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - Count is $clog2(FIFO_DEPTH)+1 bits and is zero-extended into STATUS.
- Interrupt, registered:
  - irq_o[c] = enable[c] & (count[c] ≥ max(threshold[c], 1)).
  - It updates one cycle after count or CTRL changes.
  - threshold > FIFO_DEPTH means the interrupt never fires.
- Channel enable:
  - Disabling a channel masks its interrupt only; the FIFO keeps accepting events.
- Writing CTRL does not flush the FIFO.
- Reset asserted mid-operation: FIFO contents are lost; all state returns to reset values asynchronously.

Decomposition:
- Package event_irq_pkg holds:
  - register offsets: DATA = 0x0, STATUS = 0x4, CTRL = 0x8;
  - channel stride 0x10;
  - CTRL bit-field positions;
  - the ctrl_reg_t packed struct {threshold[7:0], drop_mode, enable}.
- One sub-module, event_chan_fifo: parametrised FIFO with push/pop/full/empty/count and a drop-mode ready.
  - Instantiated NB_CHANNELS times in a generate loop.
- The top level holds the APB decode, CTRL/sticky registers and the irq registers.

Test Plan:
- Reset, then read channel 0 DATA → prdata_o = 0x0000_0000. STATUS → 0. event_ready_o = 4'b1111. irq_o = 0.
- Threshold, ch1:
  - setup: CTRL = 0x0301 (threshold 3, enable); push IDs 0x11, 0x22, 0x33;
  - irq_o[1] rises one cycle after the third push;
  - DATA reads return 0x8000_0011, 0x8000_0022, 0x8000_0033 in order;
  - irq_o[1] falls after the first read (count 2 < 3).
- Backpressure, ch2:
  - setup: drop_mode = 0; push 8 events;
  - event_ready_o[2] = 0 while valid is held on a 9th event (0xAA);
  - pop one → ready returns to 1 and 0xAA is accepted; STATUS count = 8.
- Drop mode, ch3:
  - setup: CTRL = 0x0002; fill 8 entries, push 0xBB;
  - response: ready stays 1, 0xBB is discarded, STATUS = 0x8000_0008;
  - write STATUS 0x8000_0000 → sticky clears;
  - same-cycle clear + overflow → sticky remains 1.
- Simultaneous push and pop on ch0 with count 4 → count stays 4, FIFO order is preserved across pointer wrap (20 iterations).
- Access to 0x040 (beyond 4 channels) → pslverr_o = 1, prdata_o = 0, no FIFO pops; write to CTRL bit 5 reads back 0.
